// File: rtl/o_data_pkg.sv
`default_nettype none
// ============================================================================
// Module      : o_data_pkg
// Description : Shared constants and channel state encoding for the GPIO
//               output drive block.
// Revision    : 1.0 - initial release
// ============================================================================
package o_data_pkg;

  // Per-pin mode field values (2'b11 behaves as level)
  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  // Shadow register write operations
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // Per-channel state encoding
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_PULSE     = 2'b01,
    ST_BLINK_ON  = 2'b10,
    ST_BLINK_OFF = 2'b11
  } ch_state_t;

  // Fold the reserved mode code onto level
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_LEVEL : m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/o_data_drive_out_channel.sv
`default_nettype none
// ============================================================================
// Module      : out_channel
// Description : One output pin: level, timed one-shot pulse or blink.
//               Pin is registered; done_pulse/auto_clr are single-cycle
//               strobes in the completion cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module out_channel
  import o_data_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 tick,
  input  logic                 shadow,
  input  logic [1:0]           mode,
  input  logic [LEN_WIDTH-1:0] pulse_len,
  output logic                 pin,
  output logic                 busy,
  output logic                 done_pulse,
  output logic                 auto_clr
);

  ch_state_t            r_state, w_state;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt;
  logic                 r_zero, w_zero;   // pulse was loaded with length 0
  logic                 r_prev;           // shadow seen on last enabled cycle
  logic                 r_pin, w_pin;
  logic [1:0]           w_mode;
  logic                 w_rise;
  logic                 w_cnt_zero;

  assign w_mode     = eff_mode(mode);
  assign w_rise     = shadow & ~r_prev;
  assign w_cnt_zero = (r_cnt == '0);
  assign pin        = r_pin;
  assign busy       = (r_state != ST_IDLE);

  // State register; everything freezes while enable is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_prev  <= 1'b0;
      r_pin   <= 1'b0;
    end else if (enable) begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_zero  <= w_zero;
      r_prev  <= shadow;
      r_pin   <= w_pin;
    end
  end

  // Next-state, counter and pin decode
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_zero     = r_zero;
    w_pin      = r_pin;
    done_pulse = 1'b0;
    auto_clr   = 1'b0;
    if (enable) begin
      case (r_state)
        ST_IDLE: begin
          w_cnt  = '0;
          w_zero = 1'b0;
          case (w_mode)
            MODE_PULSE: begin
              w_pin = 1'b0;
              if (w_rise) begin
                w_state = ST_PULSE;
                w_cnt   = pulse_len;
                w_zero  = (pulse_len == '0);
                w_pin   = 1'b1;
              end
            end
            MODE_BLINK: begin
              w_pin = 1'b0;
              if (shadow) begin
                w_state = ST_BLINK_ON;
                w_cnt   = pulse_len;
                w_pin   = 1'b1;
              end
            end
            default: w_pin = shadow;
          endcase
        end
        ST_PULSE: begin
          if (w_mode != MODE_PULSE || !shadow) begin
            // mode change or software clear: abort without done
            w_state = ST_IDLE;
            w_cnt   = '0;
            w_zero  = 1'b0;
            w_pin   = 1'b0;
          end else if (w_cnt_zero && (tick || r_zero)) begin
            w_state    = ST_IDLE;
            w_zero     = 1'b0;
            w_pin      = 1'b0;
            done_pulse = 1'b1;
            auto_clr   = 1'b1;
          end else if (tick) begin
            w_cnt = r_cnt - LEN_WIDTH'(1);
          end
        end
        default: begin
          if (w_mode != MODE_BLINK || !shadow) begin
            w_state = ST_IDLE;
            w_cnt   = '0;
            w_pin   = 1'b0;
          end else if (tick) begin
            if (w_cnt_zero) begin
              w_state = (r_state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
              w_pin   = (r_state == ST_BLINK_ON) ? 1'b0 : 1'b1;
              w_cnt   = pulse_len;
            end else begin
              w_cnt = r_cnt - LEN_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/o_data_drive.sv
`default_nettype none
// ============================================================================
// Module      : o_data_drive
// Description : GPIO output drive: shadow register with write/set/clear/
//               toggle ops, shared slow-tick prescaler, per-pin channels,
//               sticky done flags and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module o_data_drive
  import o_data_pkg::*;
#(
  parameter int NUM_PORTS      = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 20,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [1:0]             wr_op,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [2*NUM_PORTS-1:0] select_mode,
  input  logic [LEN_WIDTH-1:0]   pulse_len,
  input  logic [NUM_PORTS-1:0]   irq_mask,
  input  logic [NUM_PORTS-1:0]   clr,
  output logic [NUM_PORTS-1:0]   out_pins,
  output logic [DATA_WIDTH-1:0]  status,
  output logic                   irq
);

  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic                      w_tick;
  logic [NUM_PORTS-1:0]      r_shadow, w_shadow;
  logic [NUM_PORTS-1:0]      w_wr_bits, w_op_result, w_touched;
  logic [NUM_PORTS-1:0]      r_done;
  logic [NUM_PORTS-1:0]      w_busy, w_done_pulse, w_auto_clr;
  logic                      w_unused_wr;

  assign w_wr_bits   = wr_data[NUM_PORTS-1:0];
  assign w_unused_wr = ^wr_data[DATA_WIDTH-1:NUM_PORTS];
  assign w_tick      = enable && (r_presc == '1);

  // Free-running prescaler, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_presc <= '0;
    else if (enable) r_presc <= r_presc + PRESCALE_WIDTH'(1);
  end

  // Shadow update: bits touched by a write take the write result,
  // untouched bits may be auto-cleared by a completing pulse
  always_comb begin
    w_op_result = r_shadow;
    w_touched   = '0;
    if (wr_en) begin
      case (wr_op)
        OP_WRITE:  begin w_op_result = w_wr_bits;             w_touched = '1;        end
        OP_SET:    begin w_op_result = r_shadow | w_wr_bits;  w_touched = w_wr_bits; end
        OP_CLEAR:  begin w_op_result = r_shadow & ~w_wr_bits; w_touched = w_wr_bits; end
        default:   begin w_op_result = r_shadow ^ w_wr_bits;  w_touched = w_wr_bits; end
      endcase
    end
    w_shadow = (w_op_result & w_touched) | (r_shadow & ~w_auto_clr & ~w_touched);
  end

  // Shadow register; writes are accepted regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_shadow <= '0;
    else        r_shadow <= w_shadow;
  end

  // Sticky done flags: completion beats a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= '0;
    else        r_done <= (r_done & ~clr) | w_done_pulse;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_channel
    out_channel #(
      .LEN_WIDTH (LEN_WIDTH)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .tick       (w_tick),
      .shadow     (r_shadow[i]),
      .mode       (select_mode[2*i +: 2]),
      .pulse_len  (pulse_len),
      .pin        (out_pins[i]),
      .busy       (w_busy[i]),
      .done_pulse (w_done_pulse[i]),
      .auto_clr   (w_auto_clr[i])
    );
  end

  assign status = DATA_WIDTH'({r_done, w_busy});
  assign irq    = |(r_done & irq_mask);

endmodule
`default_nettype wire
